bus_arbiter: RTL and testbench

Two-master arbiter placed in front of the single-master `BUS` block. It lets two masters share the one master port of the 64-bit shared bus. Arbitration is round-robin, and a grant is held while its owner keeps requesting. A hold-limit counter forces handover when the other master is waiting. The block muxes the granted master's request, write, address and data onto the bus port and routes read data back only to the owner.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_master_mux.sv | 61 ++++++
 rtl/bus_arbiter.sv | 121 ++++++++++++
 tb/tb_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM/owner encodings,
// default bus widths and the hold-counter sizing helper.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    // Counter must reach MAX_HOLD-1; a zero-width counter is never allowed.
    function automatic int hold_cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/bus_master_mux.sv
// Combinational steering between the two masters and the single bus port:
// forwards the owner's request fields and returns read data only to the owner.
module bus_master_mux
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic [1:0]        owner,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dout,
    input  logic [DATA_W-1:0] bus_din,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    output logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m1_din
);

    logic [DATA_W-1:0] din [2];

    // Owner encoding is one-hot, so bit gi marks master gi as owner.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_din
            assign din[gi] = owner[gi] ? bus_din : '0;
        end
    endgenerate

    assign m0_din = din[0];
    assign m1_din = din[1];

    always_comb begin
        bus_req  = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = '0;
        bus_dout = '0;
        case (owner)
            OWNER_M0: begin
                bus_req  = m0_req;
                bus_wr   = m0_wr;
                bus_addr = m0_addr;
                bus_dout = m0_dout;
            end
            OWNER_M1: begin
                bus_req  = m1_req;
                bus_wr   = m1_wr;
                bus_addr = m1_addr;
                bus_dout = m1_dout;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter with a hold limit that forces handover only
// while the other master is waiting.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_wr,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m1_din,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din,
    output logic [1:0]        owner
);

    localparam int CNT_W = hold_cnt_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             last_reg;     // 1 = m1 was served last
    logic             contested;

    assign contested = ((state_reg == GRANT0) && m1_req) ||
                       ((state_reg == GRANT1) && m0_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (m0_req && m1_req) state_next = last_reg ? GRANT0 : GRANT1;
                else if (m0_req)      state_next = GRANT0;
                else if (m1_req)      state_next = GRANT1;
            end
            GRANT0: begin
                if (!m0_req)
                    state_next = m1_req ? GRANT1 : IDLE;
                else if (m1_req && (MAX_HOLD != 0) && (hold_cnt_reg >= HOLD_LAST))
                    state_next = GRANT1;
            end
            GRANT1: begin
                if (!m1_req)
                    state_next = m0_req ? GRANT0 : IDLE;
                else if (m0_req && (MAX_HOLD != 0) && (hold_cnt_reg >= HOLD_LAST))
                    state_next = GRANT0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        m0_grant = (state_reg == GRANT0);
        m1_grant = (state_reg == GRANT1);
        case (state_reg)
            GRANT0:  owner = OWNER_M0;
            GRANT1:  owner = OWNER_M1;
            default: owner = OWNER_NONE;
        endcase
    end

    // The streak counter only ages while someone else is waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_reg <= '0;
            last_reg     <= 1'b1;
        end else if ((state_next != state_reg) && (state_next != IDLE)) begin
            hold_cnt_reg <= '0;
            last_reg     <= (state_next == GRANT1);
        end else if ((state_next == state_reg) && contested && (hold_cnt_reg != CNT_MAX)) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end

    bus_master_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .owner    (owner),
        .m0_req   (m0_req),
        .m0_wr    (m0_wr),
        .m0_addr  (m0_addr),
        .m0_dout  (m0_dout),
        .m1_req   (m1_req),
        .m1_wr    (m1_wr),
        .m1_addr  (m1_addr),
        .m1_dout  (m1_dout),
        .bus_din  (bus_din),
        .bus_req  (bus_req),
        .bus_wr   (bus_wr),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .m0_din   (m0_din),
        .m1_din   (m1_din)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: three instances (MAX_HOLD 16, 4, 0) share one stimulus
// stream and are compared against a per-instance arbitration model.
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 64;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0, r1, wr0, wr1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, bdin;

    logic          g0 [N];
    logic          g1 [N];
    logic [1:0]    own [N];
    logic          breq [N];
    logic          bwr [N];
    logic [AW-1:0] baddr [N];
    logic [DW-1:0] bdout [N];
    logic [DW-1:0] din0 [N];
    logic [DW-1:0] din1 [N];

    int tests = 0;
    int fails = 0;

    int kh [N] = '{16, 4, 0};
    int mown [N];
    int mlast [N];
    int mcnt [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        bus_arbiter #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .MAX_HOLD ((gi == 0) ? 16 : ((gi == 1) ? 4 : 0))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .m0_req   (r0),
            .m1_req   (r1),
            .m0_wr    (wr0),
            .m1_wr    (wr1),
            .m0_addr  (a0),
            .m1_addr  (a1),
            .m0_dout  (d0),
            .m1_dout  (d1),
            .m0_grant (g0[gi]),
            .m1_grant (g1[gi]),
            .m0_din   (din0[gi]),
            .m1_din   (din1[gi]),
            .bus_req  (breq[gi]),
            .bus_wr   (bwr[gi]),
            .bus_addr (baddr[gi]),
            .bus_dout (bdout[gi]),
            .bus_din  (bdin),
            .owner    (own[gi])
        );
    end

    // Owner is 0 (none), 1 (m0) or 2 (m1); streak = contested cycles held.
    function automatic void model_next(input int i, output int no, output int nl, output int nc);
        int o, mine, oth;
        o = mown[i]; nl = mlast[i]; nc = mcnt[i]; oth = 0;
        if (o == 0) begin
            if (r0 && r1) no = (mlast[i] == 1) ? 2 : 1;
            else if (r0)  no = 1;
            else if (r1)  no = 2;
            else          no = 0;
        end else begin
            mine = (o == 1) ? int'(r0) : int'(r1);
            oth  = (o == 1) ? int'(r1) : int'(r0);
            if (mine != 0 && (oth == 0 || kh[i] == 0 || mcnt[i] < kh[i] - 1)) no = o;
            else if (oth != 0) no = 3 - o;
            else no = 0;
        end
        if (no != 0 && no != o) begin
            nl = no; nc = 0;
        end else if (no != 0 && oth != 0 && mcnt[i] < 100000) begin
            nc = mcnt[i] + 1;
        end
    endfunction

    task automatic advance();
        int no [N];
        int nl [N];
        int nc [N];
        for (int i = 0; i < N; i++) model_next(i, no[i], nl[i], nc[i]);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            mown[i] = no[i]; mlast[i] = nl[i]; mcnt[i] = nc[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mown[i] = 0; mlast[i] = 1; mcnt[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        r0 = 0; r1 = 0; wr0 = 0; wr1 = 0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; bdin = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        bdin = 64'h1234_5678_9ABC_DEF0;
        #1;
        for (int i = 0; i < N; i++) begin
            tests++;
            if ({g0[i], g1[i], own[i], breq[i], bwr[i]} !== 6'b0 || baddr[i] !== '0 ||
                bdout[i] !== '0 || din0[i] !== '0 || din1[i] !== '0) begin
                fails++;
                $display("FAIL reset_state dut%0d: got g=%b%b own=%b req=%b din0=%0h din1=%0h, expected all 0",
                         i, g0[i], g1[i], own[i], breq[i], din0[i], din1[i]);
            end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        r0 = 1; a0 = 16'h0056; d0 = 64'hABCD; wr0 = 1; bdin = 64'h77;
        #1;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (g0[i] !== 1'b0 || breq[i] !== 1'b0) begin
                fails++;
                $display("FAIL grant_latency dut%0d: got g0=%b bus_req=%b before edge, expected 0 0", i, g0[i], breq[i]);
            end
        end
        advance();
        for (int i = 0; i < N; i++) begin
            tests++;
            if (g0[i] !== 1'b1 || g1[i] !== 1'b0 || own[i] !== 2'b01 || baddr[i] !== 16'h0056 ||
                bdout[i] !== 64'hABCD || breq[i] !== 1'b1 || bwr[i] !== 1'b1 ||
                din1[i] !== '0 || din0[i] !== 64'h77) begin
                fails++;
                $display("FAIL single_grant dut%0d: got g0=%b own=%b addr=%h dout=%h din0=%h din1=%h, expected 1 01 0056 abcd 77 0",
                         i, g0[i], own[i], baddr[i], bdout[i], din0[i], din1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        r0 = 1; r1 = 1; a0 = 16'h1111; a1 = 16'h2222;
        advance();
        for (int i = 0; i < N; i++) begin
            tests++;
            if (own[i] !== 2'b01 || g0[i] !== 1'b1) begin
                fails++;
                $display("FAIL tie_first dut%0d: got owner=%b, expected 01", i, own[i]);
            end
        end
        r0 = 0;
        #1;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (breq[i] !== 1'b0) begin
                fails++;
                $display("FAIL release_busreq dut%0d: got bus_req=%b, expected 0", i, breq[i]);
            end
        end
        advance();
        for (int i = 0; i < N; i++) begin
            tests++;
            if (own[i] !== 2'b10 || g1[i] !== 1'b1 || g0[i] !== 1'b0 || baddr[i] !== 16'h2222) begin
                fails++;
                $display("FAIL handover dut%0d: got owner=%b g1=%b addr=%h, expected 10 1 2222", i, own[i], g1[i], baddr[i]);
            end
        end
    endtask

    task automatic test_max_hold();
        int exp_o [N];
        do_reset();
        r0 = 1; r1 = 1;
        for (int c = 1; c <= 20; c++) begin
            advance();
            exp_o[0] = (c <= 16) ? 1 : 2;
            exp_o[1] = (((c - 1) / 4) % 2 == 0) ? 1 : 2;
            exp_o[2] = 1;
            for (int i = 0; i < N; i++) begin
                tests++;
                if (int'(own[i]) != exp_o[i] || g0[i] !== (exp_o[i] == 1) || g1[i] !== (exp_o[i] == 2)) begin
                    fails++;
                    $display("FAIL max_hold dut%0d cycle %0d: got owner=%b, expected %0d", i, c, own[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_uncontested();
        do_reset();
        r1 = 1; a1 = 16'h7001; bdin = 64'd500;
        for (int c = 1; c <= 40; c++) begin
            advance();
            for (int i = 0; i < N; i++) begin
                tests++;
                if (own[i] !== 2'b10 || din1[i] !== 64'd500 || din0[i] !== '0 || baddr[i] !== 16'h7001) begin
                    fails++;
                    $display("FAIL uncontested dut%0d cycle %0d: got owner=%b din1=%0d din0=%0d, expected 10 500 0",
                             i, c, own[i], din1[i], din0[i]);
                end
            end
        end
        // A fresh streak: the MAX_HOLD=4 instance still owes m1 its full window.
        r0 = 1;
        for (int c = 1; c <= 6; c++) begin
            advance();
            tests++;
            if (int'(own[1]) != ((c < 4) ? 2 : 1)) begin
                fails++;
                $display("FAIL hold_after_idle cycle %0d: got owner=%b, expected %0d", c, own[1], (c < 4) ? 2 : 1);
            end
        end
    endtask

    task automatic test_reset_midgrant();
        do_reset();
        r0 = 1;
        advance();
        advance();
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            tests++;
            if (g0[i] !== 1'b0 || g1[i] !== 1'b0 || breq[i] !== 1'b0 || own[i] !== 2'b00) begin
                fails++;
                $display("FAIL async_reset dut%0d: got g=%b%b req=%b owner=%b, expected 0", i, g0[i], g1[i], breq[i], own[i]);
            end
        end
        model_reset();
        #2;
        reset = 1'b0;
        r1 = 1;
        advance();
        for (int i = 0; i < N; i++) begin
            tests++;
            if (own[i] !== 2'b01) begin
                fails++;
                $display("FAIL last_reset dut%0d: got owner=%b, expected 01", i, own[i]);
            end
        end
    endtask

    task automatic test_random();
        logic          er, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, e0, e1;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            r0   = ($urandom_range(0, 99) < 70);
            r1   = ($urandom_range(0, 99) < 70);
            wr0  = 1'($urandom); wr1 = 1'($urandom);
            a0   = AW'($urandom); a1 = AW'($urandom);
            d0   = {$urandom, $urandom}; d1 = {$urandom, $urandom};
            bdin = {$urandom, $urandom};
            advance();
            for (int i = 0; i < N; i++) begin
                er = 0; ew = 0; ea = '0; ed = '0; e0 = '0; e1 = '0;
                if (mown[i] == 1) begin er = r0; ew = wr0; ea = a0; ed = d0; e0 = bdin; end
                if (mown[i] == 2) begin er = r1; ew = wr1; ea = a1; ed = d1; e1 = bdin; end
                tests++;
                if (int'(own[i]) != mown[i] || g0[i] !== (mown[i] == 1) || g1[i] !== (mown[i] == 2) ||
                    breq[i] !== er || bwr[i] !== ew || baddr[i] !== ea || bdout[i] !== ed ||
                    din0[i] !== e0 || din1[i] !== e1) begin
                    fails++;
                    $display("FAIL random dut%0d cycle %0d: got owner=%b req=%b addr=%h din0=%h din1=%h, expected owner=%0d req=%b addr=%h din0=%h din1=%h",
                             i, c, own[i], breq[i], baddr[i], din0[i], din1[i], mown[i], er, ea, e0, e1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_max_hold();
        test_uncontested();
        test_reset_midgrant();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
